// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped timer: FSM state codes, register
// offsets, counting modes and CTRL field positions.
package timer_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;

   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counting timer with one-shot and auto-reload modes,
// exposing CTRL/PRESET/COUNT on a word-addressed bus and a maskable irq.
module timer_counter
   import timer_counter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;
   logic        flag;

   logic        ctrl_wr;
   logic        preset_wr;
   logic        enable;
   logic        is_reload;
   logic        cnt_load;
   logic        cnt_dec;
   logic        cnt_done;
   logic        hw_disable;
   logic        reload_clr;

   assign ctrl_wr   = we && (addr == OFF_CTRL);
   assign preset_wr = we && (addr == OFF_PRESET);
   assign enable    = ctrl[CTRL_EN];
   // Modes 2 and 3 fall back to one-shot behaviour.
   assign is_reload = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      cnt_done   = 1'b0;
      hw_disable = 1'b0;
      reload_clr = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            cnt_load  = 1'b1;
            state_nxt = ST_CNT;
         end
         ST_CNT: begin
            if (!enable) begin
               state_nxt = ST_IDLE;
            end else if (count <= 32'd1) begin
               cnt_done  = 1'b1;
               state_nxt = ST_INT;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_INT: begin
            if (is_reload) begin
               reload_clr = 1'b1;
               state_nxt  = ST_LOAD;
            end else begin
               hw_disable = 1'b1;
               state_nxt  = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A CPU write to CTRL overrides the one-shot Enable clear; a flag set
   // overrides any same-edge clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl   <= 4'd0;
         preset <= 32'd0;
         count  <= 32'd0;
         flag   <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            ctrl <= din[3:0];
         end else if (hw_disable) begin
            ctrl[CTRL_EN] <= 1'b0;
         end

         if (preset_wr) preset <= din;

         if (cnt_load) begin
            count <= preset;
         end else if (cnt_done) begin
            count <= 32'd0;
         end else if (cnt_dec) begin
            count <= count - 32'd1;
         end

         if (cnt_done) begin
            flag <= 1'b1;
         end else if (ctrl_wr || preset_wr || reload_clr) begin
            flag <= 1'b0;
         end
      end
   end

   always_comb begin
      dout = 32'd0;
      case (addr)
         OFF_CTRL:   dout = {28'd0, ctrl};
         OFF_PRESET: dout = preset;
         OFF_COUNT:  dout = count;
         default:    dout = 32'd0;
      endcase
   end

   assign irq = ctrl[CTRL_IM] & flag;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed vector table, hand-written corner
// sequences and randomized traffic against a time-based reference model.
module tb_timer_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   int total = 0;
   int bad   = 0;

   timer_counter dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .din   (din),
      .dout  (dout),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   // Reference model: counting is described by the edge at which COUNT was
   // loaded and the loaded length; the value is length minus elapsed edges.
   logic [3:0]  m_ctrl;
   logic [31:0] m_preset;
   logic [31:0] m_count;
   bit          m_flag;
   bit          m_arm;
   bit          m_on;
   bit          m_wrap;
   longint      m_len;
   longint      m_t0;
   longint      m_edge;

   task automatic model_step(input bit r, input bit w, input logic [1:0] a,
                             input logic [31:0] d);
      bit          en;
      bit          rl;
      logic [3:0]  nctrl;
      logic [31:0] npre;
      logic [31:0] ncnt;
      bit          nflag;
      bit          narm;
      bit          non;
      bit          nwrap;
      longint      rem;
      m_edge = m_edge + 1;
      if (r) begin
         m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
         m_arm = 1'b0; m_on = 1'b0; m_wrap = 1'b0;
         return;
      end
      en    = m_ctrl[0];
      rl    = (m_ctrl[2:1] == 2'd1);
      nctrl = m_ctrl; npre = m_preset; ncnt = m_count; nflag = m_flag;
      narm  = 1'b0; non = m_on; nwrap = 1'b0;
      if (m_wrap) begin
         non = 1'b0;
         if (rl) begin
            narm  = 1'b1;
            nflag = 1'b0;
         end else begin
            nctrl[0] = 1'b0;
         end
      end else if (m_arm) begin
         ncnt = m_preset;
         m_len = longint'(m_preset);
         m_t0 = m_edge;
         non = 1'b1;
      end else if (m_on) begin
         if (!en) begin
            non = 1'b0;
         end else begin
            rem = m_len - (m_edge - m_t0);
            if (rem <= 0) begin
               ncnt = 32'd0; nflag = 1'b1; nwrap = 1'b1; non = 1'b0;
            end else begin
               ncnt = rem[31:0];
            end
         end
      end else if (en) begin
         narm = 1'b1;
      end
      if (w && a == 2'd0) begin
         nctrl = d[3:0];
         if (!nwrap) nflag = 1'b0;
      end
      if (w && a == 2'd1) begin
         npre = d;
         if (!nwrap) nflag = 1'b0;
      end
      m_ctrl = nctrl; m_preset = npre; m_count = ncnt; m_flag = nflag;
      m_arm = narm; m_on = non; m_wrap = nwrap;
   endtask

   function automatic logic [31:0] model_dout(input logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_ctrl};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit w, input logic [1:0] a,
                       input logic [31:0] d);
      reset = r; we = w; addr = a; din = d;
      model_step(r, w, a, d);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          w;
      logic [1:0]  a;
      logic [31:0] d;
      logic [31:0] ed;
      bit          ei;
   } vec_t;

   vec_t tbl[19];
   int   pulse_exp[5] = '{5, 10, 15, 19, 23};

   initial begin
      bit found;
      bit ei;
      m_edge = 0; m_len = 0; m_t0 = 0;
      reset = 1'b1; we = 1'b0; addr = 2'd0; din = 32'd0;

      // One-shot with IM=1, PRESET=5, then register-map corner writes.
      tbl[0]  = '{0, 2'd0, 32'd0,          32'd0, 0};
      tbl[1]  = '{0, 2'd1, 32'd0,          32'd0, 0};
      tbl[2]  = '{0, 2'd2, 32'd0,          32'd0, 0};
      tbl[3]  = '{0, 2'd3, 32'd0,          32'd0, 0};
      tbl[4]  = '{1, 2'd1, 32'd5,          32'd5, 0};
      tbl[5]  = '{1, 2'd0, 32'h9,          32'h9, 0};
      tbl[6]  = '{0, 2'd2, 32'd0,          32'd0, 0};
      tbl[7]  = '{0, 2'd2, 32'd0,          32'd5, 0};
      tbl[8]  = '{0, 2'd2, 32'd0,          32'd4, 0};
      tbl[9]  = '{0, 2'd2, 32'd0,          32'd3, 0};
      tbl[10] = '{0, 2'd2, 32'd0,          32'd2, 0};
      tbl[11] = '{0, 2'd2, 32'd0,          32'd1, 0};
      tbl[12] = '{0, 2'd2, 32'd0,          32'd0, 1};
      tbl[13] = '{0, 2'd0, 32'd0,          32'h8, 1};
      tbl[14] = '{0, 2'd2, 32'd0,          32'd0, 1};
      tbl[15] = '{1, 2'd0, 32'h8,          32'h8, 0};
      tbl[16] = '{1, 2'd2, 32'h1234,       32'd0, 0};
      tbl[17] = '{1, 2'd3, 32'hFFFF,       32'd0, 0};
      tbl[18] = '{1, 2'd0, 32'hFFFF_FFF0,  32'd0, 0};

      step(1, 0, 2'd0, 32'd0);
      step(1, 0, 2'd0, 32'd0);
      for (int i = 0; i < 19; i++) begin
         step(0, tbl[i].w, tbl[i].a, tbl[i].d);
         chk($sformatf("tbl%0d_dout", i), dout, tbl[i].ed);
         chk($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].ei});
      end

      // PRESET=0: INT three edges after the enabling write.
      step(0, 1, 2'd1, 32'd0);
      step(0, 1, 2'd0, 32'h9);
      chk("p0_e0_irq", {31'd0, irq}, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         step(0, 0, 2'd2, 32'd0);
         chk($sformatf("p0_e%0d_count", i), dout, 32'd0);
         chk($sformatf("p0_e%0d_irq", i), {31'd0, irq}, (i == 3) ? 32'd1 : 32'd0);
      end
      step(0, 1, 2'd0, 32'd0);
      chk("p0_clear_irq", {31'd0, irq}, 32'd0);

      // Mode 0 with IM=0: flag is invisible, and unmasking clears it.
      step(0, 1, 2'd1, 32'd2);
      step(0, 1, 2'd0, 32'h1);
      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 2'd2, 32'd0);
         chk($sformatf("im0_e%0d_irq", i), {31'd0, irq}, 32'd0);
      end
      step(0, 0, 2'd0, 32'd0);
      chk("im0_ctrl_disabled", dout, 32'd0);
      step(0, 1, 2'd0, 32'h8);
      chk("im0_unmask_irq", {31'd0, irq}, 32'd0);
      step(0, 0, 2'd0, 32'd0);
      chk("im0_unmask_irq2", {31'd0, irq}, 32'd0);

      // CTRL write on the INT-entry edge, then on the INT edge itself.
      step(0, 1, 2'd1, 32'd1);
      step(0, 1, 2'd0, 32'h9);
      step(0, 0, 2'd0, 32'd0);
      step(0, 0, 2'd0, 32'd0);
      step(0, 1, 2'd0, 32'h9);
      chk("coin_set_wins_irq", {31'd0, irq}, 32'd1);
      step(0, 1, 2'd0, 32'h9);
      chk("coin_cpu_wins_ctrl", dout, 32'h9);
      chk("coin_cpu_clears_irq", {31'd0, irq}, 32'd0);
      step(0, 1, 2'd0, 32'h0);
      step(0, 0, 2'd0, 32'd0);
      step(0, 0, 2'd0, 32'd0);

      // Auto-reload PRESET=3, PRESET changed to 2 mid-count at E12.
      step(0, 1, 2'd1, 32'd3);
      step(0, 1, 2'd0, 32'hB);
      for (int i = 1; i <= 24; i++) begin
         if (i == 12) step(0, 1, 2'd1, 32'd2);
         else         step(0, 0, 2'd2, 32'd0);
         ei = 1'b0;
         foreach (pulse_exp[k]) if (pulse_exp[k] == i) ei = 1'b1;
         chk($sformatf("rl_e%0d_irq", i), {31'd0, irq}, {31'd0, ei});
         if (i >= 2 && i <= 5)
            chk($sformatf("rl_e%0d_count", i), dout, 32'(5 - i));
      end
      step(0, 1, 2'd0, 32'h0);

      // Reset asserted mid-count at COUNT=7.
      step(1, 0, 2'd0, 32'd0);
      step(0, 1, 2'd1, 32'd20);
      step(0, 1, 2'd0, 32'h9);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(0, 0, 2'd2, 32'd0);
         if (dout == 32'd7) found = 1'b1;
      end
      chk("rst_reach_count7", {31'd0, found}, 32'd1);
      step(1, 0, 2'd2, 32'd0);
      for (int a = 0; a < 4; a++) begin
         step(0, 0, 2'(a), 32'd0);
         chk($sformatf("rst_read%0d", a), dout, 32'd0);
         chk($sformatf("rst_irq%0d", a), {31'd0, irq}, 32'd0);
      end
      for (int i = 0; i < 30; i++) step(0, 0, 2'd2, 32'd0);
      chk("rst_no_int_count", dout, 32'd0);
      chk("rst_no_int_irq", {31'd0, irq}, 32'd0);

      // Randomized traffic against the reference model.
      step(1, 0, 2'd0, 32'd0);
      for (int i = 0; i < 3000; i++) begin
         bit          r;
         bit          w;
         logic [1:0]  a;
         logic [31:0] d;
         r = ($urandom_range(0, 299) == 0);
         w = ($urandom_range(0, 5) == 0);
         a = 2'($urandom_range(0, 3));
         d = (a == 2'd1) ? 32'($urandom_range(0, 6)) : 32'($urandom);
         step(r, w, a, d);
         chk($sformatf("rnd%0d_dout", i), dout, model_dout(a));
         chk($sformatf("rnd%0d_irq", i), {31'd0, irq},
             {31'd0, m_ctrl[3] & m_flag});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
